// File: rtl/lfsr_seq_ctrl.sv
// Sequencer that drives a shared register-file + ALU datapath through
// N steps of a multi-tap Fibonacci LFSR; the result is left in r1.
module lfsr_seq_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int MAX_TAPS = 4,
    parameter int TAP_W    = $clog2(DATA_W),
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_W-1:0]         seed,
    input  logic [MAX_TAPS*TAP_W-1:0] tap_pos,
    input  logic [$clog2(MAX_TAPS):0] tap_count,
    input  logic [CNT_W-1:0]          num_iter,
    input  logic                      isZero,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         raddr1,
    output logic [ADDR_W-1:0]         raddr2,
    output logic                      wen,
    output logic [ADDR_W-1:0]         waddr,
    output logic [1:0]                wdsrc,
    output logic [3:0]                func,
    output logic [DATA_W-1:0]         constant
);

    localparam int TC_W = $clog2(MAX_TAPS) + 1;

    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;

    localparam logic [ADDR_W-1:0] R_LFSR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] R_FB   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] R_CNT  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] R_TMP  = ADDR_W'(4);

    localparam logic [1:0] SRC_CONST = 2'd0;
    localparam logic [1:0] SRC_IMM   = 2'd1;
    localparam logic [1:0] SRC_REG   = 2'd2;

    typedef enum logic [3:0] {
        IDLE, LOAD_SEED, LOAD_CNT, TAP_SHIFT, TAP_ACC,
        MASK, FB_SHL, ST_SHR, MERGE, DEC, DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [TC_W-1:0]           idx_q, idx_d;
    logic [TC_W-1:0]           t_q, eff_t;
    logic [DATA_W-1:0]         seed_q;
    logic [MAX_TAPS*TAP_W-1:0] tap_q;
    logic [CNT_W-1:0]          num_q;
    logic [TAP_W-1:0]          tap_sel;

    // Zero taps still means one tap; oversized counts clamp to MAX_TAPS.
    always_comb begin
        eff_t = tap_count;
        if (tap_count == '0)
            eff_t = TC_W'(1);
        else if (tap_count > TC_W'(MAX_TAPS))
            eff_t = TC_W'(MAX_TAPS);
    end

    assign tap_sel = tap_q[int'(idx_q)*TAP_W +: TAP_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            t_q     <= '0;
            seed_q  <= '0;
            tap_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && start) begin
                seed_q <= seed;
                tap_q  <= tap_pos;
                t_q    <= eff_t;
                num_q  <= num_iter;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE:      if (start) state_d = LOAD_SEED;
            LOAD_SEED: state_d = LOAD_CNT;
            LOAD_CNT: begin
                idx_d   = '0;
                state_d = (num_q == '0) ? DONE : TAP_SHIFT;
            end
            TAP_SHIFT: begin
                if (idx_q != '0) begin
                    state_d = TAP_ACC;
                end else if (t_q == TC_W'(1)) begin
                    state_d = MASK;
                end else begin
                    idx_d = idx_q + TC_W'(1);
                end
            end
            TAP_ACC: begin
                if (idx_q == t_q - TC_W'(1)) begin
                    state_d = MASK;
                end else begin
                    idx_d   = idx_q + TC_W'(1);
                    state_d = TAP_SHIFT;
                end
            end
            MASK:   state_d = FB_SHL;
            FB_SHL: state_d = ST_SHR;
            ST_SHR: state_d = MERGE;
            MERGE:  state_d = DEC;
            DEC: begin
                idx_d   = '0;
                state_d = isZero ? DONE : TAP_SHIFT;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = 1'b0;
        raddr1   = '0;
        raddr2   = '0;
        wen      = 1'b0;
        waddr    = '0;
        wdsrc    = SRC_CONST;
        func     = '0;
        constant = '0;
        unique case (state_q)
            LOAD_SEED: begin
                wen      = 1'b1;
                waddr    = R_LFSR;
                constant = seed_q;
            end
            LOAD_CNT: begin
                wen      = 1'b1;
                waddr    = R_CNT;
                constant = DATA_W'(num_q);
            end
            TAP_SHIFT: begin
                wen      = 1'b1;
                raddr1   = R_LFSR;
                func     = ALU_SHR;
                wdsrc    = SRC_IMM;
                constant = DATA_W'(tap_sel);
                waddr    = (idx_q == '0) ? R_FB : R_TMP;
            end
            TAP_ACC: begin
                wen    = 1'b1;
                raddr1 = R_FB;
                raddr2 = R_TMP;
                func   = ALU_XOR;
                wdsrc  = SRC_REG;
                waddr  = R_FB;
            end
            MASK: begin
                wen      = 1'b1;
                raddr1   = R_FB;
                func     = ALU_AND;
                wdsrc    = SRC_IMM;
                constant = DATA_W'(1);
                waddr    = R_FB;
            end
            FB_SHL: begin
                wen      = 1'b1;
                raddr1   = R_FB;
                func     = ALU_SHL;
                wdsrc    = SRC_IMM;
                constant = DATA_W'(DATA_W - 1);
                waddr    = R_FB;
            end
            ST_SHR: begin
                wen      = 1'b1;
                raddr1   = R_LFSR;
                func     = ALU_SHR;
                wdsrc    = SRC_IMM;
                constant = DATA_W'(1);
                waddr    = R_LFSR;
            end
            MERGE: begin
                wen    = 1'b1;
                raddr1 = R_LFSR;
                raddr2 = R_FB;
                func   = ALU_OR;
                wdsrc  = SRC_REG;
                waddr  = R_LFSR;
            end
            DEC: begin
                wen      = 1'b1;
                raddr1   = R_CNT;
                func     = ALU_SUB;
                wdsrc    = SRC_IMM;
                constant = DATA_W'(1);
                waddr    = R_CNT;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a register-file + ALU model
// supplying isZero and holding the LFSR state the controller builds.
module tb_lfsr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = '0;
    logic [15:0] tap_pos = '0;
    logic [2:0]  tap_count = '0;
    logic [15:0] num_iter = '0;
    logic        isZero;
    logic        busy, done, wen;
    logic [3:0]  raddr1, raddr2, waddr, func;
    logic [1:0]  wdsrc;
    logic [15:0] constant;

    int errors = 0;
    int checks = 0;

    lfsr_seq_ctrl #(
        .DATA_W(16), .ADDR_W(4), .MAX_TAPS(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .tap_pos(tap_pos), .tap_count(tap_count), .num_iter(num_iter),
        .isZero(isZero), .busy(busy), .done(done),
        .raddr1(raddr1), .raddr2(raddr2), .wen(wen), .waddr(waddr),
        .wdsrc(wdsrc), .func(func), .constant(constant)
    );

    always #5 clk = ~clk;

    // Datapath model: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SHL=5 SHR=6
    logic [15:0] rf [16];
    logic [15:0] opb, alu_y, wd;

    function automatic logic [15:0] alu(input logic [3:0] f,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b;
            4'd6: return a >> b;
            default: return 16'h0;
        endcase
    endfunction

    always_comb begin
        opb    = (wdsrc == 2'd2) ? rf[raddr2] : constant;
        alu_y  = alu(func, rf[raddr1], opb);
        wd     = (wdsrc == 2'd0) ? constant : alu_y;
        isZero = (alu_y == 16'h0);
    end

    always @(posedge clk)
        if (wen) rf[waddr] <= wd;

    function automatic logic [15:0] lfsr_ref(input logic [15:0] s0,
                                             input logic [15:0] tp,
                                             input int t, input int n);
        logic [15:0] s;
        logic        fb;
        logic [3:0]  p;
        s = s0;
        for (int k = 0; k < n; k++) begin
            fb = 1'b0;
            for (int j = 0; j < t; j++) begin
                p  = tp[j*4 +: 4];
                fb = fb ^ s[p];
            end
            s = {fb, s[15:1]};
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // lat = cycle index (start cycle = 0) of the done pulse, -1 on timeout
    task automatic run(input logic [15:0] sd, input logic [15:0] tp,
                       input logic [2:0] tc, input logic [15:0] n,
                       input int maxc, output int lat, output bit ok);
        @(negedge clk);
        seed = sd; tap_pos = tp; tap_count = tc; num_iter = n;
        start = 1'b1;
        lat = -1;
        ok  = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) ok = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
        end
        @(negedge clk);
        if (busy || done) ok = 1'b0;
    endtask

    int lat, lat2, cnt;
    bit ok, found;
    logic [15:0] r1a, r1_done;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wen", wen, 0);
        chk("rst_const", constant, 0);
        chk("rst_func", func, 0);
        rst = 1'b0;

        // One iteration, four taps
        run(16'hACE1, 16'h5320, 3'd4, 16'd1, 40, lat, ok);
        chk("n1_lat", lat, 15);
        chk("n1_r1", rf[1], 16'h5670);
        chk("n1_r3", rf[3], 16'h0);
        chk("n1_busy", ok, 1);

        // num_iter == 0 bypasses the loop
        run(16'hBEEF, 16'h5320, 3'd4, 16'd0, 20, lat, ok);
        chk("n0_lat", lat, 3);
        chk("n0_r1", rf[1], 16'hBEEF);
        chk("n0_r3", rf[3], 16'h0);
        chk("n0_busy", ok, 1);

        // tap_count 0 -> one tap: 6 cycles per iteration
        run(16'hACE1, 16'h5320, 3'd0, 16'd2, 60, lat, ok);
        chk("tc0_lat", lat, 15);
        chk("tc0_r1", rf[1], 16'h6B38);

        // tap_count 7 saturates to 4: 12 cycles per iteration
        run(16'hACE1, 16'h5320, 3'd7, 16'd2, 60, lat, ok);
        chk("tc7_lat", lat, 27);
        chk("tc7_r1", rf[1], 16'hAB38);

        // Long run; first done must land exactly at the end
        run(16'hACE1, 16'h5320, 3'd4, 16'd3000, 36100, lat, ok);
        chk("long_lat", lat, 3 + 3000 * 12);
        chk("long_r1", rf[1], lfsr_ref(16'hACE1, 16'h5320, 4, 3000));
        chk("long_busy", ok, 1);

        // start held high, config changed mid-run
        @(negedge clk);
        seed = 16'hACE1; tap_pos = 16'h5320; tap_count = 3'd4;
        num_iter = 16'd1; start = 1'b1;
        lat = -1;
        r1a = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) begin
                seed = 16'h1234;
                tap_pos = 16'hF041;
            end
            if (done) begin
                lat = c;
                r1a = rf[1];
                break;
            end
        end
        chk("hold_lat1", lat, 15);
        chk("hold_r1a", r1a, 16'h5670);
        @(negedge clk);
        chk("hold_idle", busy, 0);
        lat2 = -1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat2 = c;
                break;
            end
        end
        chk("hold_lat2", lat2, 15);
        chk("hold_r1b", rf[1], 16'h891A);
        @(negedge clk);

        // Reset during TAP_ACC
        @(negedge clk);
        seed = 16'hACE1; tap_pos = 16'h5320; tap_count = 3'd4;
        num_iter = 16'd5; start = 1'b1;
        found = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (wen && func == 4'd4) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_found_acc", found, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wen", wen, 0);
        chk("mid_rst_done", done, 0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        chk("mid_rst_quiet", cnt, 0);
        run(16'hACE1, 16'h5320, 3'd4, 16'd1, 40, lat, ok);
        chk("post_rst_lat", lat, 15);
        chk("post_rst_r1", rf[1], 16'h5670);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
- Parametrised controller for multi-tap Fibonacci LFSR runs on the shared register-file + ALU datapath.
- Captures seed, tap list and iteration count on a start handshake.
- Emits per-cycle register-file/ALU control to run N LFSR steps, then pulses done.
- Result is left in r1. The next generation of the fixed-tap LFSR sequencer, with configurable width, taps and iteration count.

Parameters:
- DATA_W, 32, datapath/LFSR width; constant output width.
- ADDR_W, 4, register-file address width.
- MAX_TAPS, 4, maximum number of feedback taps.
- TAP_W, $clog2(DATA_W), width of one tap position.
- CNT_W, 16, iteration-count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; accepted only in IDLE.
- seed  in  DATA_W  initial LFSR state.
- tap_pos  in  MAX_TAPS*TAP_W  packed tap bit positions; tap i at [i*TAP_W +: TAP_W].
- tap_count  in  $clog2(MAX_TAPS)+1  number of taps used; 0 is treated as 1; values above MAX_TAPS saturate to MAX_TAPS.
- num_iter  in  CNT_W  LFSR steps to run.
- isZero  in  1  combinational ALU-result-zero flag from the datapath.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the run completes.
- raddr1  out  ADDR_W  register-file read port 1.
- raddr2  out  ADDR_W  register-file read port 2.
- wen  out  1  register-file write enable.
- waddr  out  ADDR_W  write address.
- wdsrc  out  2  write-data select: 0 = constant; 1 = ALU(rd1, constant); 2 = ALU(rd1, rd2).
- func  out  4  ALU opcode, from the shared ALU opcode defines (ADD, SUB, AND, OR, XOR, SHL, SHR).
- constant  out  DATA_W  immediate operand.

Behaviour:
- Register allocation: r1 = LFSR state, r2 = feedback accumulator, r3 = iteration counter, r4 = temp.
- Reset (sync, any state, including mid-run): state to IDLE; busy=0, done=0; all control outputs 0. Captured config registers are cleared.
- Control outputs are fully assigned in every state. Non-writing states drive wen=0 and all other outputs 0; no latches.
- IDLE:
  - On start=1, capture seed, tap_pos, effective tap_count T and num_iter; go to LOAD_SEED.
  - start while busy is ignored. Inputs may change freely after capture.
- LOAD_SEED: wen=1, waddr=1, wdsrc=0, constant=seed. Go to LOAD_CNT.
- LOAD_CNT: wen=1, waddr=3, wdsrc=0, constant=num_iter zero-extended.
  - If captured num_iter==0, go to DONE; else go to TAP_SHIFT with tap index i=0.
- TAP_SHIFT(i): raddr1=1, func=SHR, wdsrc=1, constant=tap[i].
  - waddr=2 when i==0, else waddr=4.
  - i==0: if T==1 go to MASK, else i++ and stay in TAP_SHIFT. i>0: go to TAP_ACC.
- TAP_ACC: raddr1=2, raddr2=4, func=XOR, wdsrc=2, waddr=2.
  - If i==T-1 go to MASK; else i++ and go to TAP_SHIFT.
- MASK: r2 = r2 AND 1 (raddr1=2, wdsrc=1, constant=1).
- FB_SHL: r2 = r2 SHL (DATA_W-1).
- ST_SHR: r1 = r1 SHR 1.
- MERGE: r1 = r1 OR r2 (raddr1=1, raddr2=2, wdsrc=2, waddr=1).
- DEC: r3 = r3 SUB 1 (raddr1=3, wdsrc=1, constant=1, waddr=3).
  - isZero is sampled in this same cycle. 1 -> DONE; 0 -> TAP_SHIFT with i=0.
- DONE: done=1, busy=1, wen=0 for exactly one cycle; then IDLE. The next start can be accepted in the following cycle.
- Iteration cost: 2T+4 cycles.
- Total latency from the start cycle to the done cycle: 3 + num_iter*(2T+4). For num_iter==0 it is 3.
- Widths: tap values are zero-extended to DATA_W on constant. Counter wrap cannot occur because the num_iter==0 case bypasses the loop.

Test Plan:
- DATA_W=16, seed=0xACE1, taps {0,2,3,5}, T=4, num_iter=1, bench regfile+ALU model -> r1=0x5670; done pulses exactly 15 cycles after the start cycle; busy high in cycles 1..15.
- Same config, num_iter=65535 -> r1 returns to 0xACE1 (maximal period); no intermediate done pulse.
- num_iter=0 -> seed written to r1, 0 written to r3, done 3 cycles after start, r1=seed.
- tap_count=0 and tap_count=7 with MAX_TAPS=4 -> behaves as T=1 and T=4 respectively; per-iteration cycle counts of 6 and 12.
- start held high through a run with seed/taps changed mid-run -> second run starts only after DONE and uses newly sampled values; first result is unaffected by the changes.
- rst asserted in TAP_ACC mid-run -> next cycle IDLE, busy=0, wen=0, no done pulse; a fresh start then completes normally.
